// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, syncs, active-area flag, line/frame strobes, frame counter.
// Latency: every output is registered and changes on the same clk edge as the pix_en advance that causes it.
// Backpressure: none; pix_en=0 freezes counters and levels, while pending strobes still clear after one clk.
module vga_timing_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic       line_start,
    output logic       frame_start,
    output logic [9:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS_END  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       hsync_nxt;
    logic       vsync_nxt;
    logic       visible_nxt;
    logic       at_line_start;
    logic       at_frame_start;

    // Levels are derived from the next counter values so they register alongside hpos/vpos.
    always_comb begin
        h_nxt = hpos + 10'd1;
        v_nxt = vpos;
        if (hpos == H_MAX) begin
            h_nxt = '0;
            v_nxt = (vpos == V_MAX) ? '0 : vpos + 10'd1;
        end
        hsync_nxt      = ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_nxt      = ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        visible_nxt    = (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
        at_line_start  = (h_nxt == '0);
        at_frame_start = (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos        <= H_MAX;
            vpos        <= V_MAX;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            visible     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else if (pix_en) begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            visible     <= visible_nxt;
            line_start  <= at_line_start;
            frame_start <= at_frame_start;
            if (at_frame_start) begin
                frame_count <= frame_count + 10'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
